four_bit_adder: RTL and testbench
=================================

// Module: four_bit_adder
// PURPOSE
//   4-bit binary adder with carry-in and carry-out, built as a ripple chain
//   of four full-adder cells, with a registered result stage.
//   It is the arithmetic core of the BCD digit adder. The BCD stage
//   concatenates {cout,sum} into a 5-bit value (0..19 for BCD operands) and
//   applies the decimal correction itself.
//   Full binary range is supported: any a, b in 0..15 and any cin.
// PARAMETERS
//   WIDTH  4  operand width; fixed at 4, no other value supported
// PORTS
//   clk        in   1  clock; all state updates on the rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   a          in   4  operand A, unsigned
//   b          in   4  operand B, unsigned
//   cin        in   1  carry-in, weight 1
//   in_valid   in   1  a/b/cin are valid this cycle; capture them
//   sum        out  4  registered low 4 bits of a+b+cin
//   cout       out  1  registered carry-out (bit 4 of a+b+cin)
//   out_valid  out  1  sum/cout hold a freshly computed result
// BEHAVIOUR
//   - Reset:
//     - When rst_n = 0, sum = 0, cout = 0 and out_valid = 0 immediately,
//       without waiting for a clock edge.
//     - These values hold while rst_n stays low.
//     - First capture is on the first rising edge with rst_n = 1.
//   - Datapath:
//     - Combinational ripple c0 = cin.
//     - Per bit i: s_i = a_i ^ b_i ^ c_i and
//       c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i.
//     - cout = c4.
//     - The result equals {cout,sum} = a + b + cin, exactly 5 bits.
//     - The sum cannot exceed 31, so there is no saturation and no overflow
//       flag.
//   - Latency: 1 cycle.
//     - When in_valid = 1 at a rising edge, sum/cout load the result of that
//       cycle's a/b/cin and out_valid = 1 after the edge.
//     - When in_valid = 0 at an edge, sum/cout keep their previous value and
//       out_valid = 0.
//   - No backpressure: a new operand may be accepted every cycle.
//     out_valid is a one-cycle pulse per accepted operand set.
//   - Inputs are sampled only at clock edges. Glitches between edges have no
//     effect.
//   - Reset asserted mid-operation:
//     - An in-flight result is discarded.
//     - Outputs go to 0 asynchronously.
//     - No result is produced for operands presented during reset.
//   - Boundary cases:
//     - 15+15+1 = 31 gives sum = 4'hF, cout = 1.
//     - 0+0+0 gives sum = 0, cout = 0.
//     - 15+0+1 = 16 gives sum = 0, cout = 1, i.e. wrap-around with carry.
// TESTING
//   1. Reset: rst_n = 0 mid-cycle with prior sum = 4'h9
//      -> sum = 0, cout = 0, out_valid = 0 at once, before any clk edge.
//   2. Basic add: a = 4, b = 5, cin = 0, in_valid = 1
//      -> next cycle sum = 9, cout = 0, out_valid = 1.
//   3. BCD range carry: a = 9, b = 9, cin = 1
//      -> sum = 4'h3, cout = 1 (19).
//      Also a = 7, b = 3, cin = 0 -> sum = 4'hA, cout = 0.
//   4. Extremes: 15+15+1 -> sum = F, cout = 1; 15+0+1 -> sum = 0, cout = 1;
//      0+0+0 -> sum = 0, cout = 0.
//   5. Exhaustive: all 512 (a,b,cin) combinations back-to-back with
//      in_valid = 1 -> each {cout,sum} = a+b+cin one cycle later;
//      out_valid held at 1.
//   6. Hold/idle: in_valid = 0 after 2+3
//      -> sum stays 5, out_valid = 0.
//      Then assert rst_n = 0 with in_valid = 1
//      -> no result captured until reset is released.

Source files
------------

// File: rtl/four_bit_adder.sv
// rtl/four_bit_adder.sv - 4-bit ripple-carry adder with carry-in/out and a registered result stage
// Arithmetic core of the BCD digit adder; {cout,sum} is the raw 5-bit binary sum.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  // Result registers hold their last value on idle cycles; out_valid pulses per accepted set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_comb;
        cout <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
// tb/tb_four_bit_adder.sv - scoreboard bench for four_bit_adder with directed, exhaustive and random stimulus

module tb_four_bit_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       cin, in_valid;
  logic [3:0] sum;
  logic       cout, out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned exp_q[$];
  bit          exp_vld;
  int unsigned last_exp;

  four_bit_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer addition of the operands the bench issued.
  always @(posedge clk) begin
    exp_vld = 1'b0;
    if (rst_n === 1'b1 && in_valid === 1'b1) begin
      exp_q.push_back(int'(a) + int'(b) + int'(cin));
      exp_vld = 1'b1;
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    exp_vld  = 1'b0;
    last_exp = 0;
  end

  always @(negedge clk) begin
    int unsigned e;
    check("out_valid", out_valid, exp_vld);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result", {cout, sum}, e);
        last_exp = e;
      end
    end else begin
      check("hold", {cout, sum}, last_exp);
    end
  end

  task automatic step(input int ia, input int ib, input int ic, input bit iv);
    a        = 4'(ia);
    b        = 4'(ib);
    cin      = ic[0];
    in_valid = iv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    in_valid = 1'b0;
    last_exp = 0;
    #1;
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Basic add, then mid-cycle reset with sum=9 showing.
    step(4, 5, 0, 1);
    check("basic_sum", sum, 9);
    check("basic_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    check("async_rst_valid", out_valid, 0);
    step(3, 3, 0, 1);
    rst_n = 1'b1;

    // BCD range and extremes.
    step(9, 9, 1, 1);
    step(7, 3, 0, 1);
    step(15, 15, 1, 1);
    step(15, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Exhaustive back-to-back.
    for (int i = 0; i < 512; i++) step(i[3:0], i[7:4], i[8], 1);
    step(0, 0, 0, 0);

    // Hold/idle, then reset while operands are offered.
    step(2, 3, 0, 1);
    step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    check("idle_hold_sum", sum, 5);
    check("idle_valid", out_valid, 0);
    rst_n = 1'b0;
    step(8, 8, 1, 1);
    step(6, 7, 1, 1);
    check("rst_no_capture_sum", sum, 0);
    check("rst_no_capture_valid", out_valid, 0);
    rst_n = 1'b1;
    step(1, 2, 1, 1);
    check("post_rst_sum", sum, 4);

    // Random stimulus with random in_valid.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3) != 0);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
